// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the RV32I multicycle controller:
// opcodes, FSM state encoding and datapath mux select encodings.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR_ADR = 4'd11,
        S_JALR_JMP = 4'd12,
        S_UPPER    = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/imm_src_decoder.sv
// Maps an opcode to its immediate format and reports whether the opcode is
// supported by this controller build.
module imm_src_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter bit ENABLE_JALR  = 1'b1,
    parameter bit ENABLE_UPPER = 1'b1
) (
    input  logic [6:0] opcode,
    output logic [2:0] imm_src,
    output logic       legal
);

    // The immediate format follows the opcode even when the opcode is disabled.
    always_comb begin
        imm_src = IMM_I;
        legal   = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_OP: legal = 1'b1;
            OPC_STORE: begin
                imm_src = IMM_S;
                legal   = 1'b1;
            end
            OPC_BRANCH: begin
                imm_src = IMM_B;
                legal   = 1'b1;
            end
            OPC_JAL: begin
                imm_src = IMM_J;
                legal   = 1'b1;
            end
            OPC_JALR: legal = ENABLE_JALR;
            OPC_LUI, OPC_AUIPC: begin
                imm_src = IMM_U;
                legal   = ENABLE_UPPER;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Multicycle RV32I main controller: steps each instruction through its
// states and drives the shared datapath strobes and mux selects.
module multicycle_main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit ENABLE_JALR   = 1'b1,
    parameter bit ENABLE_UPPER  = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit TRAP_HALT     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Branch,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       instr_done,
    output logic       illegal,
    output logic       halted,
    output logic [3:0] state_dbg
);

    state_t state_q;
    state_t state_d;
    logic   legal;
    logic   ready;

    assign ready     = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state_dbg = state_q;

    imm_src_decoder #(
        .ENABLE_JALR  (ENABLE_JALR),
        .ENABLE_UPPER (ENABLE_UPPER)
    ) u_imm_src_decoder (
        .opcode  (opcode),
        .imm_src (ImmSrc),
        .legal   (legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Strobes that depend on mem_ready stay low during wait cycles; the reset
    // override at the end keeps the FETCH request quiet while reset is held.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        IRWrite    = 1'b0;
        PCUpdate   = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        Branch     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ResultSrc  = RES_ALUOUT;
        ALUOp      = ALUOP_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = ready;
                PCUpdate  = ready;
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                if (!legal) begin
                    illegal = 1'b1;
                    if (TRAP_HALT) begin
                        state_d = S_HALT;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end else begin
                    case (opcode)
                        OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
                        OPC_OP:              state_d = S_EXECR;
                        OPC_OP_IMM:          state_d = S_EXECI;
                        OPC_BRANCH:          state_d = S_BRANCH;
                        OPC_JAL:             state_d = S_JAL;
                        OPC_JALR:            state_d = S_JALR_ADR;
                        OPC_LUI, OPC_AUIPC:  state_d = S_UPPER;
                        default:             state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_READDATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                AdrSrc     = 1'b1;
                MemWrite   = ready;
                instr_done = ready;
                if (ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUOp      = ALUOP_SUB;
                Branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                PCUpdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_JALR_ADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = S_JALR_JMP;
            end
            S_JALR_JMP: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                PCUpdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_UPPER: begin
                ALUSrcA = opcode[5] ? SRCA_ZERO : SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_FETCH;
        endcase
        if (reset) begin
            mem_req    = 1'b0;
            IRWrite    = 1'b0;
            PCUpdate   = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            Branch     = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Testbench for multicycle_main_fsm: three parameter builds driven by
// directed tables, hand-written wait/reset sequences and random instructions.
`timescale 1ns/1ps
module tb_multicycle_main_fsm;
    import riscv_ctrl_pkg::*;

    localparam logic [6:0] LW_OP    = 7'b0000011;
    localparam logic [6:0] SW_OP    = 7'b0100011;
    localparam logic [6:0] R_OP     = 7'b0110011;
    localparam logic [6:0] I_OP     = 7'b0010011;
    localparam logic [6:0] BEQ_OP   = 7'b1100011;
    localparam logic [6:0] JAL_OP   = 7'b1101111;
    localparam logic [6:0] JALR_OP  = 7'b1100111;
    localparam logic [6:0] LUI_OP   = 7'b0110111;
    localparam logic [6:0] AUIPC_OP = 7'b0010111;

    // Build 0: everything on; build 1: jalr/upper off, no handshake, skip
    // illegal; build 2: jalr off, trap to HALT.
    localparam logic [2:0] CFG_JALR  = 3'b001;
    localparam logic [2:0] CFG_UPPER = 3'b101;
    localparam logic [2:0] CFG_HS    = 3'b101;
    localparam logic [2:0] CFG_TH    = 3'b101;

    typedef struct packed {
        logic       memReq, irWrite, pcUpdate, regWrite, memWrite, branch, adrSrc;
        logic [1:0] srcA, srcB, resSrc, aluOp;
        logic [2:0] immSrc;
        logic       instrDone, illegal, halted;
    } outs_t;

    typedef enum int {
        K_FETCH, K_DECODE, K_MEMADR, K_MEMREAD, K_MEMWB, K_MEMWRITE, K_EXECR,
        K_EXECI, K_ALUWB, K_BRANCH, K_JAL, K_JALR_ADR, K_JALR_JMP, K_UPPER, K_HALT
    } kind_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] immSrc;
        int         latency;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset [3];
    logic [6:0] opcode [3];
    logic       memReady [3];
    logic       memReq [3], irWrite [3], pcUpdate [3], regWrite [3];
    logic       memWrite [3], branch [3], adrSrc [3];
    logic [1:0] aluSrcA [3], aluSrcB [3], resultSrc [3], aluOp [3];
    logic [2:0] immSrc [3];
    logic       instrDone [3], illegal [3], halted [3];
    logic [3:0] stateDbg [3];

    int    passCount = 0;
    int    checkCount = 0;
    kind_t plan [$];
    bit    readyScript [$];
    vec_t  vecs [9];
    state_t rSeq [4] = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        multicycle_main_fsm #(
            .ENABLE_JALR   (CFG_JALR[g]),
            .ENABLE_UPPER  (CFG_UPPER[g]),
            .MEM_HANDSHAKE (CFG_HS[g]),
            .TRAP_HALT     (CFG_TH[g])
        ) dut (
            .clk        (clk),
            .reset      (reset[g]),
            .opcode     (opcode[g]),
            .mem_ready  (memReady[g]),
            .mem_req    (memReq[g]),
            .IRWrite    (irWrite[g]),
            .PCUpdate   (pcUpdate[g]),
            .RegWrite   (regWrite[g]),
            .MemWrite   (memWrite[g]),
            .Branch     (branch[g]),
            .AdrSrc     (adrSrc[g]),
            .ALUSrcA    (aluSrcA[g]),
            .ALUSrcB    (aluSrcB[g]),
            .ResultSrc  (resultSrc[g]),
            .ALUOp      (aluOp[g]),
            .ImmSrc     (immSrc[g]),
            .instr_done (instrDone[g]),
            .illegal    (illegal[g]),
            .halted     (halted[g]),
            .state_dbg  (stateDbg[g])
        );
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    function automatic outs_t sampleDut(input int d);
        outs_t o;
        o.memReq    = memReq[d];
        o.irWrite   = irWrite[d];
        o.pcUpdate  = pcUpdate[d];
        o.regWrite  = regWrite[d];
        o.memWrite  = memWrite[d];
        o.branch    = branch[d];
        o.adrSrc    = adrSrc[d];
        o.srcA      = aluSrcA[d];
        o.srcB      = aluSrcB[d];
        o.resSrc    = resultSrc[d];
        o.aluOp     = aluOp[d];
        o.immSrc    = immSrc[d];
        o.instrDone = instrDone[d];
        o.illegal   = illegal[d];
        o.halted    = halted[d];
        return o;
    endfunction

    function automatic logic [8:0] strobes(input int d);
        return {memReq[d], irWrite[d], pcUpdate[d], regWrite[d], memWrite[d],
                branch[d], instrDone[d], illegal[d], halted[d]};
    endfunction

    function automatic bit isLegal(input logic [6:0] op, input int d);
        case (op)
            LW_OP, SW_OP, R_OP, I_OP, BEQ_OP, JAL_OP: return 1'b1;
            JALR_OP:            return CFG_JALR[d];
            LUI_OP, AUIPC_OP:   return CFG_UPPER[d];
            default:            return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] immModel(input logic [6:0] op);
        case (op)
            SW_OP:            return 3'd1;
            BEQ_OP:           return 3'd2;
            JAL_OP:           return 3'd3;
            LUI_OP, AUIPC_OP: return 3'd4;
            default:          return 3'd0;
        endcase
    endfunction

    // The ordered list of steps an instruction walks through.
    task automatic buildPlan(input logic [6:0] op, input int d);
        plan = '{K_FETCH, K_DECODE};
        if (!isLegal(op, d)) begin
            if (CFG_TH[d]) repeat (4) plan.push_back(K_HALT);
        end else begin
            case (op)
                LW_OP:    plan = {plan, K_MEMADR, K_MEMREAD, K_MEMWB};
                SW_OP:    plan = {plan, K_MEMADR, K_MEMWRITE};
                R_OP:     plan = {plan, K_EXECR, K_ALUWB};
                I_OP:     plan = {plan, K_EXECI, K_ALUWB};
                BEQ_OP:   plan.push_back(K_BRANCH);
                JAL_OP:   plan = {plan, K_JAL, K_ALUWB};
                JALR_OP:  plan = {plan, K_JALR_ADR, K_JALR_JMP, K_ALUWB};
                default:  plan = {plan, K_UPPER, K_ALUWB};
            endcase
        end
    endtask

    function automatic outs_t expStep(input kind_t k, input logic [6:0] op, input bit rdy, input int d);
        outs_t e = '0;
        e.immSrc = immModel(op);
        case (k)
            K_FETCH: begin
                e.memReq = 1; e.srcB = 2'd2; e.resSrc = 2'd2;
                e.irWrite = rdy; e.pcUpdate = rdy;
            end
            K_DECODE: begin
                e.srcA = 2'd1; e.srcB = 2'd1;
                if (!isLegal(op, d)) begin
                    e.illegal = 1;
                    e.instrDone = !CFG_TH[d];
                end
            end
            K_MEMADR:   begin e.srcA = 2'd2; e.srcB = 2'd1; end
            K_MEMREAD:  begin e.memReq = 1; e.adrSrc = 1; end
            K_MEMWB:    begin e.resSrc = 2'd1; e.regWrite = 1; e.instrDone = 1; end
            K_MEMWRITE: begin
                e.memReq = 1; e.adrSrc = 1; e.memWrite = rdy; e.instrDone = rdy;
            end
            K_EXECR:    begin e.srcA = 2'd2; e.aluOp = 2'd2; end
            K_EXECI:    begin e.srcA = 2'd2; e.srcB = 2'd1; e.aluOp = 2'd2; end
            K_ALUWB:    begin e.regWrite = 1; e.instrDone = 1; end
            K_BRANCH:   begin e.srcA = 2'd2; e.aluOp = 2'd1; e.branch = 1; e.instrDone = 1; end
            K_JAL:      begin e.srcA = 2'd1; e.srcB = 2'd2; e.pcUpdate = 1; end
            K_JALR_ADR: begin e.srcA = 2'd2; e.srcB = 2'd1; end
            K_JALR_JMP: begin e.srcA = 2'd1; e.srcB = 2'd2; e.pcUpdate = 1; end
            K_UPPER:    begin e.srcA = op[5] ? 2'd3 : 2'd1; e.srcB = 2'd1; end
            default:    e.halted = 1;
        endcase
        return e;
    endfunction

    // Runs one instruction from its FETCH cycle, comparing every cycle with
    // the model; mem_ready comes from readyScript first, then random or 1.
    task automatic applyStimulus(input int d, input logic [6:0] op, input bit randReady, output int doneAt);
        int  cyc = 0;
        bit  rdy, effRdy, waiting;
        doneAt = -1;
        buildPlan(op, d);
        for (int s = 0; s < plan.size(); s++) begin
            do begin
                @(negedge clk);
                if (readyScript.size() > 0) rdy = readyScript.pop_front();
                else rdy = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
                memReady[d] = rdy;
                opcode[d]   = op;
                #1;
                effRdy = CFG_HS[d] ? rdy : 1'b1;
                cyc++;
                checkOutput($sformatf("dut%0d op=%b step%0d", d, op, s),
                            sampleDut(d), expStep(plan[s], op, effRdy, d));
                if (instrDone[d] && doneAt < 0) doneAt = cyc;
                waiting = (plan[s] == K_FETCH || plan[s] == K_MEMREAD || plan[s] == K_MEMWRITE) && !effRdy;
            end while (waiting && cyc < 500);
        end
    endtask

    task automatic doReset(input int d);
        @(negedge clk);
        reset[d]    = 1'b1;
        memReady[d] = 1'b1;
        #1;
        checkOutput($sformatf("dut%0d reset strobes", d), strobes(d), 9'd0);
        checkOutput($sformatf("dut%0d reset state", d), stateDbg[d], S_FETCH);
        @(posedge clk);
        #1;
        reset[d] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done;
        logic [6:0] op;
        vecs[0] = '{LW_OP,    3'd0, 5};
        vecs[1] = '{SW_OP,    3'd1, 4};
        vecs[2] = '{R_OP,     3'd0, 4};
        vecs[3] = '{I_OP,     3'd0, 4};
        vecs[4] = '{BEQ_OP,   3'd2, 3};
        vecs[5] = '{JAL_OP,   3'd3, 4};
        vecs[6] = '{JALR_OP,  3'd0, 5};
        vecs[7] = '{LUI_OP,   3'd4, 4};
        vecs[8] = '{AUIPC_OP, 3'd4, 4};
        for (int i = 0; i < 3; i++) begin
            reset[i] = 1'b1; opcode[i] = 7'd0; memReady[i] = 1'b0;
        end

        doReset(0);
        $display("[TB] R-type state walk");
        opcode[0] = R_OP;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            memReady[0] = 1'b1;
            #1;
            checkOutput($sformatf("rtype state c%0d", i + 1), stateDbg[0], rSeq[i]);
            checkOutput($sformatf("rtype RegWrite c%0d", i + 1), regWrite[0], i == 3);
            checkOutput($sformatf("rtype instr_done c%0d", i + 1), instrDone[0], i == 3);
        end

        $display("[TB] latency / ImmSrc table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, vecs[i].op, 1'b0, done);
            checkOutput($sformatf("latency op=%b", vecs[i].op), done, vecs[i].latency);
            checkOutput($sformatf("ImmSrc op=%b", vecs[i].op), immSrc[0], vecs[i].immSrc);
        end

        readyScript = '{1, 1, 1, 0, 0, 1, 1};
        applyStimulus(0, LW_OP, 1'b0, done);
        checkOutput("lw latency with 2 waits", done, 7);
        readyScript = '{1, 1, 1, 0, 1};
        applyStimulus(0, SW_OP, 1'b0, done);
        checkOutput("sw latency with 1 wait", done, 5);

        $display("[TB] reset during MEMWRITE wait");
        opcode[0] = SW_OP;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            memReady[0] = 1'b1;
        end
        @(negedge clk);
        memReady[0] = 1'b0;
        #1;
        checkOutput("memwrite wait state", stateDbg[0], S_MEMWRITE);
        checkOutput("memwrite wait req/write", {memReq[0], memWrite[0]}, 2'b10);
        #2;
        reset[0]    = 1'b1;
        memReady[0] = 1'b1;
        #1;
        checkOutput("reset in memwrite req/write", {memReq[0], memWrite[0], regWrite[0]}, 3'b000);
        checkOutput("reset in memwrite state", stateDbg[0], S_FETCH);
        @(posedge clk);
        #1;
        memReady[0] = 1'b0;
        reset[0]    = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("after reset state", stateDbg[0], S_FETCH);
        checkOutput("after reset strobes", {memReq[0], memWrite[0], regWrite[0]}, 3'b100);

        $display("[TB] random instructions, full build");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, vecs[$urandom_range(0, 8)].op, 1'b1, done);
        end

        $display("[TB] random instructions, reduced build");
        doReset(1);
        for (int i = 0; i < 40; i++) begin
            int idx = $urandom_range(0, 11);
            op = (idx < 9) ? vecs[idx].op : 7'($urandom);
            applyStimulus(1, op, 1'b1, done);
            checkOutput($sformatf("dut1 done op=%b", op), done, (done > 0) ? done : 32'hFFFF_FFFF);
        end

        $display("[TB] illegal jalr traps to HALT");
        doReset(2);
        applyStimulus(2, JALR_OP, 1'b1, done);
        checkOutput("halt no instr_done", done, -1);
        checkOutput("halt state", stateDbg[2], S_HALT);
        doReset(2);
        applyStimulus(2, R_OP, 1'b0, done);
        checkOutput("recover after halt latency", done, 4);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
